ram_io_resp: RTL and testbench

Byte-wide memory responder on the far end of the CPU's RAM port. It executes the one-byte-per-cycle read/write transactions that the memory controller issues: a synchronous RAM array and a memory-mapped I/O window. The I/O window has a transmit FIFO, a receive FIFO, a status register and a program-end register. It sits at the top level between the CPU core and the host/UART bridge.

---
 rtl/ram_io_resp.sv | 141 ++++++++++++++
 tb/tb_ram_io_resp.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ram_io_resp.sv
// Byte-wide memory responder: synchronous RAM plus a memory-mapped I/O window
// holding TX/RX FIFOs, a status register and a program-end register.
module ram_io_resp #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned TX_DEPTH   = 8,
  parameter int unsigned RX_DEPTH   = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rw_req_in,
  input  logic [31:0] addr_in,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic [7:0]  tx_data_out,
  output logic        tx_valid_out,
  input  logic        tx_ready_in,
  input  logic [7:0]  rx_data_in,
  input  logic        rx_valid_in,
  output logic        rx_ready_out,
  output logic        io_full_out,
  output logic        overflow_out,
  output logic        sim_done_out,
  output logic [7:0]  exit_code_out
);

  localparam int unsigned RAM_WORDS = 1 << ADDR_WIDTH;
  localparam int unsigned TX_AW     = $clog2(TX_DEPTH);
  localparam int unsigned RX_AW     = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);
  localparam logic [2:0] OFF_FIFO = 3'd0;
  localparam logic [2:0] OFF_CTRL = 3'd4;

  logic [7:0] mem    [RAM_WORDS];
  logic [7:0] tx_mem [TX_DEPTH];
  logic [7:0] rx_mem [RX_DEPTH];

  logic [TX_AW-1:0] tx_rd, tx_wr;
  logic [TX_AW:0]   tx_cnt;
  logic [RX_AW-1:0] rx_rd, rx_wr;
  logic [RX_AW:0]   rx_cnt;

  logic                  is_io, act;
  logic [2:0]            off;
  logic [ADDR_WIDTH-1:0] ram_a;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic                  tx_req, tx_push, tx_pop, tx_drop;
  logic                  rx_push, rx_pop;
  logic                  ram_we, end_we;
  logic                  unused_addr;

  // Address decode and per-cycle transaction strobes
  always_comb begin
    is_io    = (addr_in[17:16] == 2'b11);
    off      = addr_in[2:0];
    ram_a    = addr_in[ADDR_WIDTH-1:0];
    act      = rdy_in && !rst_in;
    tx_full  = (tx_cnt == TX_FULL_CNT);
    tx_empty = (tx_cnt == '0);
    rx_full  = (rx_cnt == RX_FULL_CNT);
    rx_empty = (rx_cnt == '0);
    tx_pop   = act && tx_ready_in && !tx_empty;
    tx_req   = act && is_io && rw_req_in && (off == OFF_FIFO);
    tx_push  = tx_req && (!tx_full || tx_pop);
    tx_drop  = tx_req && tx_full && !tx_pop;
    rx_pop   = act && is_io && !rw_req_in && (off == OFF_FIFO) && !rx_empty;
    rx_push  = act && rx_valid_in && !rx_full;
    ram_we   = act && !is_io && rw_req_in;
    end_we   = act && is_io && rw_req_in && (off == OFF_CTRL);
  end

  assign unused_addr  = ^addr_in;
  assign tx_valid_out = act && !tx_empty;
  assign rx_ready_out = act && !rx_full;
  assign io_full_out  = tx_full;
  assign tx_data_out  = tx_empty ? 8'h00 : tx_mem[tx_rd];

  // RAM array: no reset, write port only
  always_ff @(posedge clk_in) begin
    if (ram_we) mem[ram_a] <= data_in;
  end

  // FIFO storage
  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wr] <= data_in;
    if (rx_push) rx_mem[rx_wr] <= rx_data_in;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tx_rd  <= '0;
      tx_wr  <= '0;
      tx_cnt <= '0;
      rx_rd  <= '0;
      rx_wr  <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + TX_AW'(1);
      if (tx_pop)  tx_rd <= tx_rd + TX_AW'(1);
      tx_cnt <= tx_cnt + (TX_AW+1)'(tx_push) - (TX_AW+1)'(tx_pop);
      if (rx_push) rx_wr <= rx_wr + RX_AW'(1);
      if (rx_pop)  rx_rd <= rx_rd + RX_AW'(1);
      rx_cnt <= rx_cnt + (RX_AW+1)'(rx_push) - (RX_AW+1)'(rx_pop);
    end
  end

  // Sticky flags and program-end register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      overflow_out  <= 1'b0;
      sim_done_out  <= 1'b0;
      exit_code_out <= 8'h00;
    end else begin
      if (tx_drop) overflow_out <= 1'b1;
      if (end_we) begin
        sim_done_out  <= 1'b1;
        exit_code_out <= data_in;
      end
    end
  end

  // Read data register; writes and stalls leave it unchanged
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      data_out <= 8'h00;
    end else if (rdy_in && !rw_req_in) begin
      if (is_io) begin
        case (off)
          OFF_FIFO: data_out <= rx_pop ? rx_mem[rx_rd] : 8'h00;
          OFF_CTRL: data_out <= {6'b0, !rx_empty, tx_full};
          default:  data_out <= 8'h00;
        endcase
      end else begin
        data_out <= mem[ram_a];
      end
    end
  end

endmodule

// File: tb/tb_ram_io_resp.sv
// Directed self-checking bench for ram_io_resp: RAM, TX/RX FIFOs, status,
// program-end register, rdy_in stalls and reset.
module tb_ram_io_resp;

  logic        clk = 1'b0;
  logic        rst, rdy, rw;
  logic [31:0] addr;
  logic [7:0]  wdata, rdata, tx_data, rx_data, exit_code;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
  logic        io_full, overflow, sim_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_io_resp dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .rdy_in       (rdy),
    .rw_req_in    (rw),
    .addr_in      (addr),
    .data_in      (wdata),
    .data_out     (rdata),
    .tx_data_out  (tx_data),
    .tx_valid_out (tx_valid),
    .tx_ready_in  (tx_ready),
    .rx_data_in   (rx_data),
    .rx_valid_in  (rx_valid),
    .rx_ready_out (rx_ready),
    .io_full_out  (io_full),
    .overflow_out (overflow),
    .sim_done_out (sim_done),
    .exit_code_out(exit_code)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    rw = 1'b1; addr = a; wdata = d;
    tick();
  endtask

  task automatic rd(input logic [31:0] a);
    rw = 1'b0; addr = a;
    tick();
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rw = 1'b0; addr = '0; wdata = '0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    tick(); tick();
    chk("rst_data_out", 32'(rdata), 32'h00);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_rx_ready", 32'(rx_ready), 32'h0);
    chk("rst_io_full", 32'(io_full), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_sim_done", 32'(sim_done), 32'h0);
    chk("rst_exit_code", 32'(exit_code), 32'h00);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    rst = 1'b0; #1;
    chk("post_rst_rx_ready", 32'(rx_ready), 32'h1);

    // RAM write then pipelined read-back
    wr(32'h10, 8'h5A);
    chk("write_holds_data_out", 32'(rdata), 32'h00);
    wr(32'h11, 8'hA5);
    rd(32'h10);
    chk("ram_rd_10", 32'(rdata), 32'h5A);
    rd(32'h11);
    chk("ram_rd_11", 32'(rdata), 32'hA5);

    // Read issued before an overlapping write returns the old byte
    wr(32'h20, 8'h11);
    rd(32'h20);
    chk("rdw_old", 32'(rdata), 32'h11);
    wr(32'h20, 8'h22);
    chk("rdw_hold", 32'(rdata), 32'h11);
    rd(32'h20);
    chk("rdw_new", 32'(rdata), 32'h22);
    wr(32'h50, 8'h12);

    // TX FIFO fill to full, ninth byte dropped
    for (int i = 1; i <= 9; i++) begin
      wr(32'h30000, 8'(i));
      if (i == 7) chk("tx_not_full_7", 32'(io_full), 32'h0);
      if (i == 8) begin
        chk("tx_full_8", 32'(io_full), 32'h1);
        chk("tx_no_ovf_8", 32'(overflow), 32'h0);
      end
    end
    chk("tx_ovf_9", 32'(overflow), 32'h1);
    rw = 1'b0; addr = 32'h40; tx_ready = 1'b1; #1;
    for (int i = 1; i <= 8; i++) begin
      chk("tx_drain_valid", 32'(tx_valid), 32'h1);
      chk("tx_drain_data", 32'(tx_data), 32'(i));
      tick();
    end
    chk("tx_drained", 32'(tx_valid), 32'h0);
    chk("tx_drained_full", 32'(io_full), 32'h0);

    // Push and pop together at full keeps the count
    tx_ready = 1'b0;
    for (int i = 1; i <= 8; i++) wr(32'h30000, 8'(8'h80 + i));
    tx_ready = 1'b1;
    wr(32'h30000, 8'h90);
    chk("tx_pushpop_full", 32'(io_full), 32'h1);
    chk("tx_pushpop_head", 32'(tx_data), 32'h82);
    rw = 1'b0; addr = 32'h40; #1;
    for (int i = 2; i <= 9; i++) begin
      chk("tx_pp_drain", 32'(tx_data), (i == 9) ? 32'h90 : 32'(8'h80 + i));
      tick();
    end
    chk("tx_pp_empty", 32'(tx_valid), 32'h0);

    // rdy_in stall during TX drain and RAM write
    tx_ready = 1'b0;
    wr(32'h30, 8'h33);
    wr(32'h30000, 8'h61);
    wr(32'h30000, 8'h62);
    wr(32'h30000, 8'h63);
    rw = 1'b0; addr = 32'h40; tx_ready = 1'b1; #1;
    chk("stall_head0", 32'(tx_data), 32'h61);
    tick();
    chk("stall_head1", 32'(tx_data), 32'h62);
    rdy = 1'b0; rw = 1'b1; addr = 32'h30; wdata = 8'hEE; #1;
    chk("stall_tx_valid", 32'(tx_valid), 32'h0);
    chk("stall_rx_ready", 32'(rx_ready), 32'h0);
    tick(); tick();
    chk("stall_head_kept", 32'(tx_data), 32'h62);
    rdy = 1'b1; rw = 1'b0; addr = 32'h30; #1;
    chk("resume_valid", 32'(tx_valid), 32'h1);
    tick();
    chk("stall_ram_kept", 32'(rdata), 32'h33);
    chk("resume_head", 32'(tx_data), 32'h63);
    tick();
    chk("resume_empty", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;

    // RX path
    rx_valid = 1'b1; rx_data = 8'h41; tick();
    rx_data = 8'h42; tick();
    rx_valid = 1'b0;
    rd(32'h30004);
    chk("rx_status", 32'(rdata), 32'h02);
    rd(32'h30000);
    chk("rx_pop0", 32'(rdata), 32'h41);
    rd(32'h30000);
    chk("rx_pop1", 32'(rdata), 32'h42);
    rd(32'h30000);
    chk("rx_pop_empty", 32'(rdata), 32'h00);
    rd(32'h30004);
    chk("rx_status_empty", 32'(rdata), 32'h00);
    rx_valid = 1'b1; rx_data = 8'h55;
    rd(32'h30000);
    chk("rx_pushpop_empty", 32'(rdata), 32'h00);
    rx_valid = 1'b0;
    rd(32'h30000);
    chk("rx_pushpop_stored", 32'(rdata), 32'h55);
    rd(32'h30002);
    chk("io_other_off", 32'(rdata), 32'h00);

    // Program end and reset with a pending RAM write
    wr(32'h30004, 8'h07);
    chk("sim_done", 32'(sim_done), 32'h1);
    chk("exit_code", 32'(exit_code), 32'h07);
    wr(32'h30004, 8'h09);
    chk("exit_code_over", 32'(exit_code), 32'h09);
    rst = 1'b1;
    wr(32'h50, 8'h77);
    chk("rst_sim_done2", 32'(sim_done), 32'h0);
    chk("rst_exit_code2", 32'(exit_code), 32'h00);
    chk("rst_overflow2", 32'(overflow), 32'h0);
    rst = 1'b0;
    rd(32'h50);
    chk("rst_write_dropped", 32'(rdata), 32'h12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
